// File: rtl/posmap_walk_ctrl_pkg.sv
// Shared constants, command encodings and level-address helpers for the PosMap walk.
package posmap_walk_ctrl_pkg;
  localparam int ORAMU          = 32;
  localparam int ORAML          = 20;
  localparam int LeafWidth      = 32;
  localparam int LogLeafInBlock = 4;
  localparam int LeafInBlock    = 1 << LogLeafInBlock;
  localparam int ORAMN          = 2**20;
  localparam int NumLevels      = 3;
  localparam int LvlW           = 2;
  localparam int CntW           = LogLeafInBlock + 1;

  localparam logic [1:0] CacheWrite      = 2'b00;
  localparam logic [1:0] CacheRead       = 2'b01;
  localparam logic [1:0] CacheRefill     = 2'b10;
  localparam logic [1:0] CacheInitRefill = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_LWAIT, S_BE_RD, S_BE_RDDATA,
    S_REFILL_CMD, S_REFILL, S_EV_REQ, S_EV_DATA, S_RESP
  } walk_state_e;

  // First address of level i: each level stacks above the (rounded-up) size of the one below.
  function automatic logic [ORAMU-1:0] base_addr(input int i);
    logic [ORAMU-1:0] b;
    b = '0;
    for (int k = 1; k < NumLevels; k++)
      if (k <= i)
        b = b + ORAMU'((ORAMN + (1 << ((k-1)*LogLeafInBlock)) - 1) >> ((k-1)*LogLeafInBlock));
    return b;
  endfunction

  function automatic logic [ORAMU-1:0] level_addr(input logic [ORAMU-1:0] a, input logic [LvlW-1:0] lvl);
    return base_addr(int'(lvl)) + (a >> (int'(lvl) * LogLeafInBlock));
  endfunction
endpackage

// File: rtl/posmap_walk_ctrl_block_buf.sv
// One PosMap block of storage with independent fill and drain pointers.
// Writers must gate wr_en with !full; readers gate rd_en with !empty.
module posmap_walk_ctrl_block_buf
  import posmap_walk_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [LeafWidth-1:0] wr_data,
  input  logic                 rd_en,
  output logic [LeafWidth-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic                 drained
);
  logic [LeafWidth-1:0] mem_q [LeafInBlock];
  logic [LeafWidth-1:0] mem_d [LeafInBlock];
  logic [CntW-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  assign rd_data = mem_q[rd_cnt_q[LogLeafInBlock-1:0]];
  assign full    = (wr_cnt_q == CntW'(LeafInBlock));
  assign empty   = (rd_cnt_q == wr_cnt_q);
  assign drained = (rd_cnt_q == CntW'(LeafInBlock));

  // Pointer advance and word capture; clear restarts both pointers for a new block.
  always_comb begin
    mem_d    = mem_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (clr) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_cnt_q[LogLeafInBlock-1:0]] = wr_data;
        wr_cnt_d = wr_cnt_q + CntW'(1);
      end
      if (rd_en) rd_cnt_d = rd_cnt_q + CntW'(1);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LeafInBlock; i++) mem_q[i] <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
endmodule

// File: rtl/posmap_walk_ctrl.sv
// Sequences one frontend leaf request into the recursive PosMap walk:
// lookups climb until a level hits, then each missed level is fetched,
// refilled into the PLB (writing back any eviction) and looked up again.
module posmap_walk_ctrl
  import posmap_walk_ctrl_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [ORAMU-1:0]     ReqAddr,
  output logic                 LeafValid,
  input  logic                 LeafReady,
  output logic [ORAML-1:0]     LeafOld,
  output logic [ORAML-1:0]     LeafNew,
  output logic                 LeafUnInit,
  output logic                 PPPCmdValid,
  input  logic                 PPPCmdReady,
  output logic [1:0]           PPPCmd,
  output logic [ORAMU-1:0]     PPPAddr,
  input  logic                 PPPOutValid,
  output logic                 PPPOutReady,
  input  logic                 PPPHit,
  input  logic                 PPPUnInit,
  input  logic [ORAML-1:0]     PPPOldLeaf,
  input  logic [ORAML-1:0]     PPPNewLeaf,
  input  logic                 PPPEvict,
  input  logic [ORAMU-1:0]     PPPEvictAddr,
  output logic                 PPPRefillValid,
  output logic [LeafWidth-1:0] PPPRefillData,
  input  logic                 PPPRefillReady,
  input  logic                 PPPEvictDataValid,
  input  logic [LeafWidth-1:0] PPPEvictData,
  output logic                 BEReqValid,
  input  logic                 BEReqReady,
  output logic                 BEWrite,
  output logic [ORAMU-1:0]     BEAddr,
  output logic [ORAML-1:0]     BEOldLeaf,
  output logic [ORAML-1:0]     BENewLeaf,
  input  logic                 BERdValid,
  output logic                 BERdReady,
  input  logic [LeafWidth-1:0] BERdData,
  output logic                 BEWrValid,
  input  logic                 BEWrReady,
  output logic [LeafWidth-1:0] BEWrData
);
  walk_state_e          state_q, state_d;
  logic [LvlW-1:0]      lvl_q, lvl_d;
  logic [ORAMU-1:0]     addr_q, addr_d, ev_addr_q, ev_addr_d;
  logic [ORAML-1:0]     old_q, old_d, new_q, new_d, ev_leaf_q, ev_leaf_d;
  logic                 unin_q, unin_d, rdy_q;
  logic                 start, ref_clr, ev_clr;
  logic                 ref_wr, ref_rd, ref_full, ref_empty, ref_drained;
  logic                 ev_wr, ev_rd, ev_full, ev_empty, ev_drained;
  logic [LeafWidth-1:0] ref_rd_data, ev_rd_data;
  logic [ORAMU-1:0]     refill_addr;

  assign refill_addr = level_addr(addr_q, lvl_q) & ~ORAMU'(LeafInBlock - 1);
  assign ref_wr      = BERdValid && BERdReady;
  assign ref_rd      = PPPRefillValid && PPPRefillReady;
  assign ev_wr       = PPPEvictDataValid && !ev_full;
  assign ev_rd       = BEWrValid && BEWrReady;

  posmap_walk_ctrl_block_buf u_refill_buf (
    .clk(Clock), .rst(Reset), .clr(start || ref_clr),
    .wr_en(ref_wr), .wr_data(BERdData), .rd_en(ref_rd), .rd_data(ref_rd_data),
    .full(ref_full), .empty(ref_empty), .drained(ref_drained)
  );

  posmap_walk_ctrl_block_buf u_evict_buf (
    .clk(Clock), .rst(Reset), .clr(start || ev_clr),
    .wr_en(ev_wr), .wr_data(PPPEvictData), .rd_en(ev_rd), .rd_data(ev_rd_data),
    .full(ev_full), .empty(ev_empty), .drained(ev_drained)
  );

  // State and walk-context registers; rdy_q keeps ReqReady low while in reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      lvl_q     <= '0;
      addr_q    <= '0;
      old_q     <= '0;
      new_q     <= '0;
      unin_q    <= 1'b0;
      ev_addr_q <= '0;
      ev_leaf_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      addr_q    <= addr_d;
      old_q     <= old_d;
      new_q     <= new_d;
      unin_q    <= unin_d;
      ev_addr_q <= ev_addr_d;
      ev_leaf_q <= ev_leaf_d;
      rdy_q     <= 1'b1;
    end
  end

  // Next state, level tracking and result/eviction capture.
  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    addr_d    = addr_q;
    old_d     = old_q;
    new_d     = new_q;
    unin_d    = unin_q;
    ev_addr_d = ev_addr_q;
    ev_leaf_d = ev_leaf_q;
    start     = 1'b0;
    ref_clr   = 1'b0;
    ev_clr    = 1'b0;
    case (state_q)
      S_IDLE: if (ReqValid && rdy_q) begin
        addr_d  = ReqAddr;
        lvl_d   = '0;
        start   = 1'b1;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: if (PPPCmdReady) state_d = S_LWAIT;
      S_LWAIT: if (PPPOutValid) begin
        if (!PPPHit) begin
          lvl_d   = lvl_q + LvlW'(1);
          state_d = S_LOOKUP;
        end else begin
          old_d  = PPPOldLeaf;
          new_d  = PPPNewLeaf;
          unin_d = PPPUnInit;
          if (lvl_q == '0) state_d = S_RESP;
          else begin
            lvl_d   = lvl_q - LvlW'(1);
            ref_clr = 1'b1;
            state_d = PPPUnInit ? S_REFILL_CMD : S_BE_RD;
          end
        end
      end
      S_BE_RD:     if (BEReqReady) state_d = S_BE_RDDATA;
      S_BE_RDDATA: if (ref_full) state_d = S_REFILL_CMD;
      S_REFILL_CMD: if (PPPCmdReady) begin
        ev_clr  = 1'b1;
        state_d = S_REFILL;
      end
      S_REFILL: if (PPPOutValid && PPPOutReady) begin
        if (PPPEvict) begin
          ev_addr_d = PPPEvictAddr;
          ev_leaf_d = PPPNewLeaf;
          state_d   = S_EV_REQ;
        end else state_d = S_LOOKUP;
      end
      S_EV_REQ:  if (BEReqReady) state_d = S_EV_DATA;
      S_EV_DATA: if (ev_drained) state_d = S_LOOKUP;
      S_RESP:    if (LeafReady) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake and payload outputs; payloads are zero outside the state that owns them.
  always_comb begin
    ReqReady       = 1'b0;
    LeafValid      = 1'b0;
    LeafOld        = '0;
    LeafNew        = '0;
    LeafUnInit     = 1'b0;
    PPPCmdValid    = 1'b0;
    PPPCmd         = CacheWrite;
    PPPAddr        = '0;
    PPPOutReady    = 1'b0;
    PPPRefillValid = 1'b0;
    PPPRefillData  = '0;
    BEReqValid     = 1'b0;
    BEWrite        = 1'b0;
    BEAddr         = '0;
    BEOldLeaf      = '0;
    BENewLeaf      = '0;
    BERdReady      = 1'b0;
    BEWrValid      = 1'b0;
    BEWrData       = '0;
    case (state_q)
      S_IDLE:   ReqReady = rdy_q;
      S_LOOKUP: begin
        PPPCmdValid = 1'b1;
        PPPCmd      = CacheWrite;
        PPPAddr     = level_addr(addr_q, lvl_q);
      end
      S_LWAIT: PPPOutReady = 1'b1;
      S_BE_RD: begin
        BEReqValid = 1'b1;
        BEAddr     = refill_addr;
        BEOldLeaf  = old_q;
        BENewLeaf  = new_q;
      end
      S_BE_RDDATA: BERdReady = !ref_full;
      S_REFILL_CMD: begin
        PPPCmdValid = 1'b1;
        PPPCmd      = unin_q ? CacheInitRefill : CacheRefill;
        PPPAddr     = refill_addr;
      end
      S_REFILL: begin
        // The buffer is full before streaming, so words go out back to back.
        PPPRefillValid = !unin_q && !ref_empty;
        PPPRefillData  = PPPRefillValid ? ref_rd_data : '0;
        PPPOutReady    = unin_q || ref_drained;
      end
      S_EV_REQ: begin
        BEReqValid = 1'b1;
        BEWrite    = 1'b1;
        BEAddr     = ev_addr_q;
        BEOldLeaf  = ev_leaf_q;
        BENewLeaf  = ev_leaf_q;
      end
      S_EV_DATA: begin
        BEWrValid = !ev_empty;
        BEWrData  = BEWrValid ? ev_rd_data : '0;
      end
      S_RESP: begin
        LeafValid  = 1'b1;
        LeafOld    = old_q;
        LeafNew    = new_q;
        LeafUnInit = unin_q;
      end
      default: ;
    endcase
  end

  // The top level lives on chip and must always hit.
  assert property (@(posedge Clock) disable iff (Reset)
    !(state_q == S_LWAIT && PPPOutValid && !PPPHit && lvl_q == LvlW'(NumLevels - 1)));
endmodule

// File: tb/tb_posmap_walk_ctrl.sv
// Directed walk vectors for posmap_walk_ctrl; the bench plays the PPP and backend.
module tb_posmap_walk_ctrl;
  logic Clock = 0, Reset = 1;
  logic ReqValid = 0, LeafReady = 0, PPPCmdReady = 0, PPPOutValid = 0, PPPHit = 0, PPPUnInit = 0;
  logic PPPEvict = 0, PPPRefillReady = 0, PPPEvictDataValid = 0, BEReqReady = 0, BERdValid = 0, BEWrReady = 0;
  logic [31:0] ReqAddr = 0, PPPEvictAddr = 0, PPPEvictData = 0, BERdData = 0;
  logic [19:0] PPPOldLeaf = 0, PPPNewLeaf = 0;
  logic ReqReady, LeafValid, LeafUnInit, PPPCmdValid, PPPOutReady, PPPRefillValid;
  logic BEReqValid, BEWrite, BERdReady, BEWrValid;
  logic [19:0] LeafOld, LeafNew, BEOldLeaf, BENewLeaf;
  logic [1:0]  PPPCmd;
  logic [31:0] PPPAddr, PPPRefillData, BEAddr, BEWrData;

  posmap_walk_ctrl dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .LeafValid(LeafValid), .LeafReady(LeafReady), .LeafOld(LeafOld), .LeafNew(LeafNew), .LeafUnInit(LeafUnInit),
    .PPPCmdValid(PPPCmdValid), .PPPCmdReady(PPPCmdReady), .PPPCmd(PPPCmd), .PPPAddr(PPPAddr),
    .PPPOutValid(PPPOutValid), .PPPOutReady(PPPOutReady), .PPPHit(PPPHit), .PPPUnInit(PPPUnInit),
    .PPPOldLeaf(PPPOldLeaf), .PPPNewLeaf(PPPNewLeaf), .PPPEvict(PPPEvict), .PPPEvictAddr(PPPEvictAddr),
    .PPPRefillValid(PPPRefillValid), .PPPRefillData(PPPRefillData), .PPPRefillReady(PPPRefillReady),
    .PPPEvictDataValid(PPPEvictDataValid), .PPPEvictData(PPPEvictData),
    .BEReqValid(BEReqValid), .BEReqReady(BEReqReady), .BEWrite(BEWrite), .BEAddr(BEAddr),
    .BEOldLeaf(BEOldLeaf), .BENewLeaf(BENewLeaf), .BERdValid(BERdValid), .BERdReady(BERdReady),
    .BERdData(BERdData), .BEWrValid(BEWrValid), .BEWrReady(BEWrReady), .BEWrData(BEWrData)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;
  int n_cmd = 0, n_be = 0, n_ref = 0;

  // Handshake counters used for the per-walk activity checks.
  always @(posedge Clock) if (!Reset) begin
    if (PPPCmdValid && PPPCmdReady) n_cmd++;
    if (BEReqValid && BEReqReady) n_be++;
    if (PPPRefillValid && PPPRefillReady) n_ref++;
  end

  typedef struct {
    logic [31:0] addr; int hit; bit unin; bit ev; logic [31:0] ev_addr; logic [19:0] ev_leaf;
    logic [31:0] a0, a1, a2; logic [19:0] ro, rn; int hold; int rst_at;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit sel(input int w);
    case (w)
      0: return PPPCmdValid;
      1: return BEReqValid;
      2: return LeafValid;
      3: return PPPOutReady;
      4: return ReqReady;
      default: return BERdReady;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string nm);
    int n = 0;
    while (!sel(w) && n < 200) begin @(negedge Clock); n++; end
    if (!sel(w)) begin
      checks++; errors++;
      $display("FAIL timeout_%s actual=0 expected=1", nm);
    end
  endtask

  task automatic ppp_cmd(input logic [1:0] c, input logic [31:0] a, input string nm);
    wait_sig(0, nm);
    chk({nm, "_cmd"}, 64'(PPPCmd), 64'(c));
    chk({nm, "_addr"}, 64'(PPPAddr), 64'(a));
    PPPCmdReady = 1; @(negedge Clock); PPPCmdReady = 0;
  endtask

  task automatic ppp_res(input bit hit, input bit unin, input bit ev,
                         input logic [19:0] o, input logic [19:0] n, input logic [31:0] ea);
    PPPOutValid = 1; PPPHit = hit; PPPUnInit = unin; PPPEvict = ev;
    PPPOldLeaf = o; PPPNewLeaf = n; PPPEvictAddr = ea;
    wait_sig(3, "out_rdy");
    @(negedge Clock);
    PPPOutValid = 0; PPPHit = 0; PPPUnInit = 0; PPPEvict = 0; PPPOldLeaf = 0; PPPNewLeaf = 0; PPPEvictAddr = 0;
  endtask

  task automatic be_req(input bit w, input logic [31:0] a, input logic [19:0] o, input logic [19:0] n, input string nm);
    wait_sig(1, nm);
    chk({nm, "_write"}, 64'(BEWrite), 64'(w));
    chk({nm, "_addr"}, 64'(BEAddr), 64'(a));
    chk({nm, "_old"}, 64'(BEOldLeaf), 64'(o));
    chk({nm, "_new"}, 64'(BENewLeaf), 64'(n));
    BEReqReady = 1; @(negedge Clock); BEReqReady = 0;
  endtask

  function automatic logic [31:0] rw(input int l, input int k);
    return 32'hC000_0000 | 32'(l << 8) | 32'(k);
  endfunction
  function automatic logic [31:0] ew(input int l, input int k);
    return 32'hE000_0000 | 32'(l << 8) | 32'(k);
  endfunction

  task automatic zero_inputs();
    ReqValid = 0; LeafReady = 0; PPPCmdReady = 0; PPPOutValid = 0; PPPHit = 0; PPPUnInit = 0;
    PPPEvict = 0; PPPRefillReady = 0; PPPEvictDataValid = 0; BEReqReady = 0; BERdValid = 0; BEWrReady = 0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ctl"}, 64'({ReqReady, LeafValid, PPPCmdValid, PPPOutReady, PPPRefillValid,
                          BEReqValid, BERdReady, BEWrValid, BEWrite, LeafUnInit}), 64'(0));
    chk({nm, "_data"}, 64'(PPPAddr | PPPRefillData | BEAddr | BEWrData | 32'(PPPCmd)), 64'(0));
    chk({nm, "_leaf"}, 64'(LeafOld | LeafNew | BEOldLeaf | BENewLeaf), 64'(0));
  endtask

  task automatic run_walk(input vec_t v);
    logic [31:0] la[3];
    int c0, b0, r0, got, cyc;
    la[0] = v.a0; la[1] = v.a1; la[2] = v.a2;
    c0 = n_cmd; b0 = n_be; r0 = n_ref;
    wait_sig(4, "req_rdy");
    ReqValid = 1; ReqAddr = v.addr; @(negedge Clock); ReqValid = 0;
    for (int l = 0; l <= v.hit; l++) begin
      ppp_cmd(2'b00, la[l], "lookup_up");
      if (l < v.hit) ppp_res(0, 0, 0, 20'h0, 20'h0, 32'h0);
      else if (l == 0) ppp_res(1, 0, 0, v.ro, v.rn, 32'h0);
      else ppp_res(1, v.unin, 0, 20'h100 + 20'(l), 20'h200 + 20'(l), 32'h0);
    end
    for (int l = v.hit - 1; l >= 0; l--) begin
      if (!v.unin) begin
        // Stray read data before the request must be ignored.
        BERdValid = 1; BERdData = 32'hDEAD_BEEF;
        be_req(0, la[l] & ~32'hF, 20'h100 + 20'(l + 1), 20'h200 + 20'(l + 1), "be_rd");
        BERdValid = 0;
        for (int k = 0; k < 16; k++) begin
          BERdValid = 1; BERdData = rw(l, k);
          wait_sig(5, "be_rd_rdy");
          @(negedge Clock);
        end
        BERdValid = 0;
      end
      ppp_cmd(v.unin ? 2'b11 : 2'b10, la[l] & ~32'hF, "refill_cmd");
      if (!v.unin) begin
        PPPRefillReady = 1;
        for (int k = 0; k < 16; k++) begin
          chk("refill_valid", 64'(PPPRefillValid), 64'(1));
          chk("refill_data", 64'(PPPRefillData), 64'(rw(l, k)));
          PPPEvictDataValid = v.ev; PPPEvictData = ew(l, k);
          if (k == v.rst_at) begin
            Reset = 1; #1;
            chk_outputs_zero("reset_mid");
            zero_inputs();
            @(negedge Clock); @(negedge Clock);
            Reset = 0;
            @(negedge Clock);
            return;
          end
          @(negedge Clock);
        end
        PPPEvictDataValid = 0; PPPRefillReady = 0;
        chk("refill_stop", 64'(PPPRefillValid), 64'(0));
      end
      ppp_res(1, 0, v.ev, 20'h0, v.ev_leaf, v.ev_addr);
      if (v.ev) begin
        be_req(1, v.ev_addr, v.ev_leaf, v.ev_leaf, "ev_req");
        got = 0; cyc = 0;
        while (got < 16 && cyc < 300) begin
          BEWrReady = cyc[0];
          if (BEWrValid && BEWrReady) begin
            chk("ev_wr_data", 64'(BEWrData), 64'(ew(l, got)));
            got++;
          end
          @(negedge Clock); cyc++;
        end
        BEWrReady = 0;
        chk("ev_wr_cnt", 64'(got), 64'(16));
      end
      ppp_cmd(2'b00, la[l], "lookup_dn");
      if (l == 0) ppp_res(1, 0, 0, v.ro, v.rn, 32'h0);
      else ppp_res(1, v.unin, 0, 20'h100 + 20'(l), 20'h200 + 20'(l), 32'h0);
    end
    wait_sig(2, "leaf_vld");
    for (int c = 0; c <= v.hold; c++) begin
      chk("leaf_valid", 64'(LeafValid), 64'(1));
      chk("leaf_old", 64'(LeafOld), 64'(v.ro));
      chk("leaf_new", 64'(LeafNew), 64'(v.rn));
      chk("leaf_uninit", 64'(LeafUnInit), 64'(0));
      if (c == v.hold) LeafReady = 1;
      @(negedge Clock);
    end
    LeafReady = 0;
    chk("req_ready_after", 64'(ReqReady), 64'(1));
    chk("n_cmd", 64'(n_cmd - c0), 64'(3 * v.hit + 1));
    chk("n_be", 64'(n_be - b0), 64'((v.unin ? 0 : v.hit) + (v.ev ? v.hit : 0)));
    chk("n_refill", 64'(n_ref - r0), 64'(v.unin ? 0 : 16 * v.hit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    //        addr         hit unin ev  ev_addr   ev_leaf   a0           a1            a2           ro         rn        hold rst
    tv[0] = '{32'h35,      0, 0, 0, 32'h0,  20'h0,   32'h35,      32'h100003,  32'h110000, 20'h00123, 20'h0ABCD, 0, -1};
    tv[1] = '{32'h35,      1, 0, 0, 32'h0,  20'h0,   32'h35,      32'h100003,  32'h110000, 20'h00AAA, 20'h00BBB, 3, -1};
    tv[2] = '{32'h35,      1, 0, 1, 32'h40, 20'h777, 32'h35,      32'h100003,  32'h110000, 20'h00C01, 20'h00C02, 0, -1};
    tv[3] = '{32'h35,      1, 1, 0, 32'h0,  20'h0,   32'h35,      32'h100003,  32'h110000, 20'h00D01, 20'h00D02, 1, -1};
    tv[4] = '{32'h12345,   2, 0, 1, 32'h50, 20'h888, 32'h12345,   32'h101234,  32'h110123, 20'hFFFFF, 20'h00001, 10, -1};
    tv[5] = '{32'h35,      1, 0, 0, 32'h0,  20'h0,   32'h35,      32'h100003,  32'h110000, 20'h0, 20'h0, 0, 7};
    tv[6] = '{32'h000FFFFF,2, 0, 0, 32'h0,  20'h0,   32'h000FFFFF,32'h10FFFF,  32'h110FFF, 20'h12345, 20'h6789A, 1, -1};

    @(negedge Clock); @(negedge Clock);
    chk_outputs_zero("reset");
    Reset = 0;
    @(negedge Clock);
    chk("ready_out_of_reset", 64'(ReqReady), 64'(1));

    for (int i = 0; i < 7; i++) run_walk(tv[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/posmap_walk_ctrl.md
Name: posmap_walk_ctrl

Overview:
- Initiator-side sequencer for the PosMap/PLB unit (the PPP). It turns one frontend request for a data block's leaf into the full recursive PosMap walk.
- Upward phase: issues update (remap) lookups level by level until one hits.
- Downward phase: for each missed level, fetches the PosMap block from the ORAM backend, refills the PLB with it, writes back any evicted PLB block, and re-issues the lookup.
- Sits between the frontend request queue, the PPP command/result/refill/evict ports, and the backend access port.

Parameters:
- ORAMU, 32, block address width.
- ORAML, 20, leaf width.
- LeafWidth, 32, PPP data word width: {valid bit, leaf}, zero-padded.
- LogLeafInBlock, 4, log2 of PosMap entries per block; LeafInBlock = 16.
- ORAMN, 2**20, number of data blocks.
- NumLevels, 3, recursion levels including the on-chip level; the last level always hits.

Ports:
- Clock in 1; Reset in 1 (asynchronous, active-high).
- ReqValid in 1; ReqReady out 1; ReqAddr in ORAMU — frontend data block address.
- LeafValid out 1; LeafReady in 1; LeafOld out ORAML; LeafNew out ORAML; LeafUnInit out 1 — final level-0 result.
- PPPCmdValid out 1; PPPCmdReady in 1; PPPCmd out 2 (00 update, 01 read, 10 refill, 11 init-refill); PPPAddr out ORAMU.
- PPPOutValid in 1; PPPOutReady out 1; PPPHit in 1; PPPUnInit in 1; PPPOldLeaf in ORAML; PPPNewLeaf in ORAML; PPPEvict in 1; PPPEvictAddr in ORAMU.
- PPPRefillValid out 1; PPPRefillData out LeafWidth; PPPRefillReady in 1.
- PPPEvictDataValid in 1; PPPEvictData in LeafWidth.
- BEReqValid out 1; BEReqReady in 1; BEWrite out 1; BEAddr out ORAMU; BEOldLeaf out ORAML; BENewLeaf out ORAML.
- BERdValid in 1; BERdReady out 1; BERdData in LeafWidth.
- BEWrValid out 1; BEWrReady in 1; BEWrData out LeafWidth.

Behaviour:
- **Reset values:** every valid/ready output is 0, all data outputs are 0, state is IDLE, Lvl = 0, buffer counters = 0. Reset mid-operation abandons the walk with no further handshakes.
- **Level address:** LevelAddr(i) = Base(i) + (ReqAddr >> (i*LogLeafInBlock)).
  - Base(0) = 0; Base(i) = Base(i-1) + ceil(ORAMN >> ((i-1)*LogLeafInBlock)).
  - Width is ORAMU; overflow is a configuration error.
  - Refill address = LevelAddr(i) with the low LogLeafInBlock bits cleared.
- **IDLE:** ReqReady = 1. On the ReqValid&&ReqReady transfer, latch ReqAddr, set Lvl = 0, go to LOOKUP.
- **LOOKUP:** assert PPPCmdValid with Cmd = 00 and PPPAddr = LevelAddr(Lvl) until PPPCmdReady; then go to LWAIT.
- **LWAIT:** PPPOutReady = 1 and the result is consumed in the transfer cycle.
  - Miss: Lvl++ and go to LOOKUP. If Lvl = NumLevels-1 misses, this is a fatal simulation error.
  - Hit with Lvl = 0: latch the result and go to RESP.
  - Hit with Lvl > 0: latch OldLeaf/NewLeaf/UnInit as the parent leaves, Lvl--. Go to REFILL_CMD if UnInit, otherwise BE_RD.
- **BE_RD:** BE read request with BEWrite = 0, BEAddr = refill address, BEOldLeaf/BENewLeaf = parent leaves. Then BE_RDDATA.
- **BE_RDDATA:** BERdReady = 1. Accepts exactly LeafInBlock words into RefillBuf, then goes to REFILL_CMD.
- **REFILL_CMD:** Cmd = 10, or 11 if the parent was UnInit, at the refill address. Then REFILL.
- **REFILL:** for Cmd 10, once PPPRefillReady rises, PPPRefillValid stays high for LeafInBlock consecutive cycles with no bubbles. RefillBuf is fully loaded before streaming starts, which guarantees this. Cmd 11 streams nothing.
  - Evict words arriving on PPPEvictDataValid are written into EvictBuf at 1 word/cycle, in any cycle.
  - On the PPP result (PPPOutReady = 1):
    - if PPPEvict, latch PPPEvictAddr and PPPNewLeaf (the evicted block's stored leaf), then go to EV_REQ;
    - otherwise go to LOOKUP at the new Lvl.
- **EV_REQ:** BE write with BEWrite = 1, BEAddr = evicted address, BEOldLeaf = BENewLeaf = evicted leaf. Then EV_DATA.
- **EV_DATA:** drain EvictBuf on BEWr* (LeafInBlock words). Drain may start before EvictBuf is full; a read beyond the fill count stalls BEWrValid. After the last word, go to LOOKUP.
- **RESP:** LeafValid = 1 with the registered level-0 leaves held stable until LeafReady; then IDLE. A new request is accepted in the cycle after the LeafValid&&LeafReady transfer.
- **Backpressure:** every valid holds its payload stable until its ready. BERdValid words arriving outside BE_RDDATA are not accepted.
- **Simultaneous:** an evict word on the last cycle of REFILL streaming is captured normally.

Decomposition:
- Shared package (PathORAM/PLB headers): Base(i) as a constant function; cache command encodings (CacheWrite/Read/Refill/InitRefill); LeafInBlock.
- Sub-module `block_buf`: LeafInBlock x LeafWidth register file with independent fill/drain counters and Full/Empty flags.
  - Instantiated twice: RefillBuf and EvictBuf.
  - Clear on Reset and at walk start.

Test Plan:
- **On-chip hit:** level-0 hit with Old = 0x00123, New = 0x0ABCD → exactly one PPP command (00, ReqAddr); LeafOld = 0x00123; no BE activity.
- **One-level miss:** ReqAddr = 0x35, Lvl 0 misses, Lvl 1 hits at ORAMN+3 → BE read at refill address 0x30 with the parent leaves; refill Cmd 10 of 16 bubble-free words, no evict; re-lookup at 0x35; response returned.
- **Evict path:** refill result with Evict = 1, EvictAddr = 0x40, leaf 0x777 → BE write with address 0x40, old = new = 0x777, carrying the 16 captured evict words in order.
- **UnInit parent:** Lvl 1 hit with UnInit = 1 → Cmd 11 issued, zero BE reads, zero PPPRefillValid cycles.
- **Backpressure:** LeafReady held low for 10 cycles and BEWrReady toggled → outputs stay stable; no words are lost or duplicated.
- **Reset mid-REFILL:** Reset asserted at word 7 → all outputs are 0 in the same cycle; the next request completes normally.
